// File: rtl/ps2_keycode_if.sv
// PS/2 pins into the keycode decoder and decoded key events out of it.
// master: board pins + keycode consumers; slave: the decoder itself.
interface ps2_keycode_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keycode,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output key_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 set-2 receiver/decoder producing the HID code of the most recently pressed, still-held key.
// Latency: pin edge to fall_tick 2+FILTER_LEN, stop-bit fall_tick to keycode/key_valid +3, to frame_err +2.
// No backpressure: PS/2 is device-clocked, every accepted byte is decoded immediately.
module ps2_keycode #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic          Clk,
    input  logic          Reset_n,
    ps2_keycode_if.slave  bus
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, filt_flip, fall_tick;
    logic [FW-1:0] filt_cnt;
    logic [1:0]    state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] to_cnt;
    logic          byte_rdy;
    logic [7:0]    rx_byte;
    logic          ext, brk, is_prefix;
    logic [7:0]    hid_code, next_kc;
    logic [7:0]    keycode_q;
    logic          key_valid_q, frame_err_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock follows the synchronized pin only after FILTER_LEN differing samples in a row.
    assign filt_flip = (clk_s2 != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            filt_clk  <= 1'b1;
            filt_cnt  <= '0;
            fall_tick <= 1'b0;
        end else begin
            fall_tick <= filt_flip && !clk_s2;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_flip) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            to_cnt      <= '0;
            byte_rdy    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_rdy    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (fall_tick && !dat_s2) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (fall_tick) begin
                        shreg  <= {dat_s2, shreg[9:1]};
                        to_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            state <= ST_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        state       <= ST_IDLE;
                        frame_err_q <= 1'b1;
                        to_cnt      <= '0;
                        bit_cnt     <= '0;
                        shreg       <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // shreg = {stop, parity, data[7:0]}; odd parity over data+parity.
                    if ((^shreg[8:0]) && shreg[9]) begin
                        byte_rdy <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_byte = shreg[7:0];

    function automatic logic [7:0] hid_of(input logic e, input logic [7:0] b);
        logic [7:0] h;
        h = 8'd0;
        case ({e, b})
            9'h01D: h = 8'd26;
            9'h01C: h = 8'd4;
            9'h01B: h = 8'd22;
            9'h023: h = 8'd7;
            9'h029: h = 8'd44;
            9'h05A: h = 8'd40;
            9'h076: h = 8'd41;
            9'h175: h = 8'd82;
            9'h172: h = 8'd81;
            9'h16B: h = 8'd80;
            9'h174: h = 8'd79;
            9'h15A: h = 8'd40;
            default: h = 8'd0;
        endcase
        return h;
    endfunction

    assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0) ||
                       (rx_byte == 8'hAA) || (rx_byte == 8'hFA);
    assign hid_code  = hid_of(ext, rx_byte);

    always_comb begin
        next_kc = keycode_q;
        if (byte_rdy && !is_prefix && (hid_code != 8'd0)) begin
            if (!brk) begin
                next_kc = hid_code;
            end else if (keycode_q == hid_code) begin
                next_kc = 8'd0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            keycode_q   <= 8'd0;
            key_valid_q <= 1'b0;
        end else begin
            keycode_q   <= next_kc;
            key_valid_q <= (next_kc != keycode_q);
            if (byte_rdy) begin
                if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else if (!is_prefix) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

    assign bus.keycode   = keycode_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode.sv
// Directed PS/2 frames against a key-state model; every cycle checks keycode and pulse timing.
module tb_ps2_keycode;
    localparam int F   = 8;
    localparam int TMO = 2000;
    localparam int H   = 40;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    ps2_keycode_if bus ();

    ps2_keycode #(.FILTER_LEN(F), .TIMEOUT(TMO)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         lo;
        int         hi;
        bit         kv;
        bit         fe;
        logic [7:0] kc;
    } ev_t;

    ev_t        evq[$];
    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 1'b0;
    bit         hit;
    logic [7:0] exp_kc = 8'd0;
    logic [7:0] m_kc   = 8'd0;
    bit         m_ext  = 1'b0;
    bit         m_brk  = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Expected pulses come from the event queue; everywhere else both pulses must be low.
    always @(negedge Clk) begin
        if (chk_en) begin
            hit = 1'b0;
            if (evq.size() > 0 && cyc >= evq[0].lo && cyc <= evq[0].hi &&
                bus.key_valid === evq[0].kv && bus.frame_err === evq[0].fe) begin
                exp_kc = evq[0].kc;
                void'(evq.pop_front());
                hit = 1'b1;
            end
            checks++;
            if (!hit && (bus.key_valid !== 1'b0 || bus.frame_err !== 1'b0)) begin
                errors++;
                $display("FAIL pulse cyc=%0d key_valid=%b frame_err=%b expected 0/0",
                         cyc, bus.key_valid, bus.frame_err);
            end
            if (evq.size() > 0 && cyc > evq[0].hi) begin
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d wanted kv=%b fe=%b in [%0d,%0d], saw none",
                         cyc, evq[0].kv, evq[0].fe, evq[0].lo, evq[0].hi);
                exp_kc = evq[0].kc;
                void'(evq.pop_front());
            end
            checks++;
            if (bus.keycode !== exp_kc) begin
                errors++;
                $display("FAIL keycode cyc=%0d got %0d expected %0d", cyc, bus.keycode, exp_kc);
            end
        end
    end

    function automatic logic [7:0] hid(input bit e, input logic [7:0] b);
        if (!e) begin
            case (b)
                8'h1D: return 8'd26;
                8'h1C: return 8'd4;
                8'h1B: return 8'd22;
                8'h23: return 8'd7;
                8'h29: return 8'd44;
                8'h5A: return 8'd40;
                8'h76: return 8'd41;
                default: return 8'd0;
            endcase
        end
        case (b)
            8'h75: return 8'd82;
            8'h72: return 8'd81;
            8'h6B: return 8'd80;
            8'h74: return 8'd79;
            8'h5A: return 8'd40;
            default: return 8'd0;
        endcase
    endfunction

    function automatic void push_ev(input int at_lo, input int at_hi, input bit kv, input bit fe,
                                    input logic [7:0] kc);
        ev_t e;
        e.lo = at_lo;
        e.hi = at_hi;
        e.kv = kv;
        e.fe = fe;
        e.kc = kc;
        evq.push_back(e);
    endfunction

    // Key-state rules applied to one accepted byte whose stop edge left the pin in cycle n.
    function automatic void model_byte(input logic [7:0] b, input int n);
        logic [7:0] h;
        logic [7:0] nk;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hAA && b != 8'hFA) begin
            h  = hid(m_ext, b);
            nk = m_kc;
            if (h != 8'd0) begin
                if (!m_brk) nk = h;
                else if (m_kc == h) nk = 8'd0;
            end
            if (nk != m_kc) push_ev(n + F + 5, n + F + 5, 1'b1, 1'b0, nk);
            m_kc  = nk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                              input int nbits, output int nlast);
        logic [10:0] bits;
        bits  = {stop_ok, (par_ok ? ~^b : ^b), b, 1'b0};
        nlast = 0;
        for (int i = 0; i < nbits; i++) begin
            @(posedge Clk); #1 bus.ps2_data = bits[i];
            repeat (H) @(posedge Clk);
            #1 bus.ps2_clk = 1'b0;
            nlast = cyc;
            if (i == 10) begin
                if (par_ok && stop_ok) model_byte(b, nlast);
                else push_ev(nlast + F + 4, nlast + F + 4, 1'b0, 1'b1, m_kc);
            end
            repeat (H) @(posedge Clk);
            #1 bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        repeat (2 * H) @(posedge Clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        int n;
        send_frame(b, 1'b1, 1'b1, 11, n);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, expv);
        end
    endtask

    initial begin
        int nl;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        Reset_n      = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        chk("reset_keycode",   32'(bus.keycode),   0);
        chk("reset_key_valid", 32'(bus.key_valid), 0);
        chk("reset_frame_err", 32'(bus.frame_err), 0);
        Reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (100) @(posedge Clk);
        #1 chk("idle_keycode", 32'(bus.keycode), 0);

        send_ok(8'h1D);                   #1 chk("press_w", 32'(bus.keycode), 26);
        send_ok(8'h1D);                   #1 chk("repeat_w", 32'(bus.keycode), 26);
        send_ok(8'h1C);                   #1 chk("press_a", 32'(bus.keycode), 4);
        send_ok(8'hF0); send_ok(8'h1D);   #1 chk("break_other", 32'(bus.keycode), 4);
        send_ok(8'hF0); send_ok(8'h1C);   #1 chk("break_held", 32'(bus.keycode), 0);

        send_ok(8'hE0); send_ok(8'h75);   #1 chk("ext_up", 32'(bus.keycode), 82);
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h75);
        #1 chk("ext_up_break", 32'(bus.keycode), 0);
        send_ok(8'h1D);
        send_ok(8'h75);                   #1 chk("unmapped_75", 32'(bus.keycode), 26);
        send_ok(8'hF0); send_ok(8'h1D);   #1 chk("release_w", 32'(bus.keycode), 0);

        send_frame(8'h1D, 1'b0, 1'b1, 11, nl);  #1 chk("bad_parity", 32'(bus.keycode), 0);
        send_frame(8'h1D, 1'b1, 1'b0, 11, nl);  #1 chk("bad_stop", 32'(bus.keycode), 0);

        // Five falling edges then silence: abort expected about TIMEOUT cycles after the last tick.
        send_frame(8'h1D, 1'b1, 1'b1, 5, nl);
        push_ev(nl + 2 + F + TMO - 4, nl + 2 + F + TMO + 4, 1'b0, 1'b1, m_kc);
        repeat (TMO + 100) @(posedge Clk);
        send_ok(8'h23);                   #1 chk("after_timeout", 32'(bus.keycode), 7);

        // Short low glitches with data low would start a frame (and later time out) if they leaked.
        bus.ps2_data = 1'b0;
        for (int g = 0; g < 5; g++) begin
            @(posedge Clk); #1 bus.ps2_clk = 1'b0;
            repeat (3) @(posedge Clk);
            #1 bus.ps2_clk = 1'b1;
            repeat (20) @(posedge Clk);
        end
        repeat (TMO + 200) @(posedge Clk);
        #1 bus.ps2_data = 1'b1;
        chk("glitch_keycode", 32'(bus.keycode), 7);

        send_frame(8'h1C, 1'b1, 1'b1, 4, nl);
        chk_en = 1'b0;
        @(posedge Clk); #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_keycode",   32'(bus.keycode),   0);
        chk("async_rst_key_valid", 32'(bus.key_valid), 0);
        chk("async_rst_frame_err", 32'(bus.frame_err), 0);
        repeat (10) @(posedge Clk);
        evq.delete();
        exp_kc = 8'd0;
        m_kc   = 8'd0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        @(posedge Clk); #1 Reset_n = 1'b1;
        chk_en = 1'b1;
        send_ok(8'h1C);                   #1 chk("after_reset", 32'(bus.keycode), 4);

        repeat (50) @(posedge Clk);
        chk_en = 1'b0;
        chk("pending_events", 32'(evq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_keycode.md
# ps2_keycode

PS/2 keyboard receiver and decoder that produces the 8-bit USB HID-style `keycode` consumed by the player-motion and game-control logic. It deserializes PS/2 device-to-host frames, tracks make/break/extended prefixes, and translates the supported set-2 scancodes to HID usage codes. `keycode` holds the most recently pressed key that is still held, and returns to 0 when that key is released. The block sits between the board PS/2 pins and every `keycode` consumer, and replaces the USB/NIOS keycode path on boards without USB.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT`, 100000: Clk cycles without a falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).

Ports:
- `Clk`, input, 1: system clock. The design has one clock.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `ps2_clk`, input, 1: PS/2 clock pin, asynchronous to `Clk`.
- `ps2_data`, input, 1: PS/2 data pin, asynchronous to `Clk`.
- `keycode`, output, 8: HID code of the held key; 0 means no supported key is held.
- `key_valid`, output, 1: one-cycle pulse whenever `keycode` changes value.
- `frame_err`, output, 1: one-cycle pulse when a frame is discarded because of parity, stop bit, or timeout.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through 2 synchronizer flops.
  - Filtered clock: it changes level only after `FILTER_LEN` consecutive identical synchronized samples.
  - `fall_tick` is a one-cycle strobe when the filtered clock goes 1 to 0.
  - The data bit is sampled from synchronized `ps2_data` in the `fall_tick` cycle.
- Frame FSM, with states IDLE, SHIFT and CHECK:
  - IDLE: on `fall_tick` with data 0 (start bit), go to SHIFT with the bit count at 0. On `fall_tick` with data 1, stay in IDLE with no error.
  - SHIFT: each `fall_tick` shifts the data bit in, LSB first. Bits 0-7 are data, bit 8 is odd parity, bit 9 is stop. After the stop bit, go to CHECK.
  - CHECK (1 cycle): the byte is accepted only if XOR of data and parity is 1 and stop is 1. Accepted: `byte_rdy` pulses for one cycle. Rejected: `frame_err` pulses. Either way, return to IDLE.
  - Timeout: the counter resets on every `fall_tick` and is active only in SHIFT. When it reaches `TIMEOUT`, go to IDLE, pulse `frame_err`, and discard the partial byte.
- Byte decoder, acting on `byte_rdy`, with flags `ext` and `brk`:
  - E0 sets `ext`. F0 sets `brk`.
  - AA (BAT) and FA (ACK) are ignored and leave the flags unchanged.
  - Any other byte is translated using `ext`, then both flags are cleared.
- Translation table:
  - Non-extended: 1D→26 (W), 1C→4 (A), 1B→22 (S), 23→7 (D), 29→44 (Space), 5A→40 (Enter), 76→41 (Esc).
  - Extended: 75→82 (Up), 72→81 (Down), 6B→80 (Left), 74→79 (Right), 5A→40 (keypad Enter).
  - Anything else maps to 0, meaning unmapped.
- Keycode update:
  - Make with mapped code H: `keycode` becomes H (last press wins).
  - Break with mapped code H and `keycode == H`: `keycode` becomes 0.
  - Break of any other key: no change.
  - Unmapped code: no change.
- `key_valid` pulses only when the registered value actually changes. Typematic repeats of the held key produce no pulse.

## Timing
- Reset (async assert, synchronous deassert handled at top level) forces:
  - `keycode` = 0, `key_valid` = 0, `frame_err` = 0;
  - FSM to IDLE, the bit count, shift register, timeout counter, `ext` and `brk` to 0;
  - filter output to 1 and synchronizers to 1.
- Latency, counting from the `fall_tick` cycle of the stop bit:
  - CHECK occupies cycle +1.
  - `byte_rdy` is asserted in cycle +2.
  - `keycode` and `key_valid` are visible in cycle +3.
  - `frame_err` for a bad frame is visible in cycle +2.
  - Pin-to-`fall_tick` latency is 2 + `FILTER_LEN` cycles.
- `key_valid` and `frame_err` are never high in the same cycle, and never high for 2 consecutive cycles from a single frame.
- Reset mid-frame: the partial frame is lost. The remaining device edges are treated as a new frame; any resulting error or timeout is absorbed by the normal error path.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no `fall_tick`.

## Test plan
Bench settings for all scenarios: `FILTER_LEN` = 8, `TIMEOUT` = 2000, PS/2 half-period of 40 Clk cycles.
- Reset then idle: `keycode` = 0 and no pulses. Send 1D: `keycode` = 26, with `key_valid` high exactly 1 cycle at the stop-edge cycle +3.
- Send 1D then 1C: `keycode` goes 26, then 4. Send F0 1D: stays 4 with no pulse. Send F0 1C: goes to 0 with one pulse.
- Send E0 75, then E0 F0 75: `keycode` goes 82, then 0. Send 75 without E0: no change, because 75 is unmapped non-extended.
- Send 1D with a bad parity bit: `frame_err` pulses once and `keycode` stays 0. Send a frame with stop = 0: `frame_err` pulses once.
- Send 5 clock edges, then silence: after 2000 cycles `frame_err` pulses and the FSM is in IDLE. The next valid 23 gives `keycode` = 7.
- 3-cycle low glitches on `ps2_clk` during idle produce no `fall_tick` and no outputs. Pulling `Reset_n` low mid-frame drives all outputs to 0 immediately (asynchronously).
